// File: rtl/wyswietl_pkg.sv
// Shared constants for the 7-segment display path: segment patterns, scan slot indices, anode constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wyswietl_pkg;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'b1111111;

  // Scan slot numbers; slot N drives anode N (anode 0 = rightmost digit).
  localparam logic [1:0] SLOT_MIN2 = 2'd0;
  localparam logic [1:0] SLOT_MIN1 = 2'd1;
  localparam logic [1:0] SLOT_HR2  = 2'd2;
  localparam logic [1:0] SLOT_HR1  = 2'd3;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low one-hot anode for a slot.
  function automatic logic [3:0] anode_for(input logic [1:0] slot);
    return ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern; values 10..15 render as a dash.
// Latency: 0 cycles (pure combinational).
// Backpressure: none. Ports: bcd (4b in), seg (7b out, {g,f,e,d,c,b,a}).
module bcd_to_7seg
  import wyswietl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/wyswietlacz_mux.sv
// 4-digit multiplexed common-anode 7-segment driver with shadow-latched digits and a blinking colon.
// Latency: slot/shadow/colon changes reach an_o/seg_o/dp_o one cycle later; each digit is held REFRESH_DIV cycles.
// Backpressure: none; upd_i and sec_tick_i are single-cycle strobes that are always accepted.
// Ports: clk_i, rst_i (sync, active-high); hr1_i/hr2_i/min1_i/min2_i BCD digits; upd_i latch strobe;
//        sec_tick_i colon toggle; an_o anodes, seg_o segments, dp_o colon (all active-low).
module wyswietlacz_mux
  import wyswietl_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] hr1_i,
  input  logic [3:0] hr2_i,
  input  logic [3:0] min1_i,
  input  logic [3:0] min2_i,
  input  logic       upd_i,
  input  logic       sec_tick_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    slot;
  logic [1:0]    sh_hr1;
  logic [3:0]    sh_hr2;
  logic [3:0]    sh_min1;
  logic [3:0]    sh_min2;
  logic          colon_q;

  logic          slot_tc;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic          blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign slot_tc = (presc == PRESC_LAST);

  // Digit selection always reads the shadow copy, never the live inputs,
  // so a half-updated time from the counter is never displayed.
  always_comb begin
    cur_digit = sh_min2;
    case (slot)
      SLOT_MIN2: cur_digit = sh_min2;
      SLOT_MIN1: cur_digit = sh_min1;
      SLOT_HR2:  cur_digit = sh_hr2;
      SLOT_HR1:  cur_digit = {2'b00, sh_hr1};
      default:   cur_digit = sh_min2;
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // A blanked slot still takes its full scan time; it just lights nothing.
  always_comb begin
    blank   = (BLANK_LZ != 0) && (slot == SLOT_HR1) && (sh_hr1 == 2'd0);
    an_nxt  = blank ? AN_OFF  : anode_for(slot);
    seg_nxt = blank ? SEG_OFF : cur_seg;
    dp_nxt  = !((slot == SLOT_HR2) && colon_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc   <= '0;
      slot    <= SLOT_MIN2;
      sh_hr1  <= '0;
      sh_hr2  <= '0;
      sh_min1 <= '0;
      sh_min2 <= '0;
      colon_q <= 1'b0;
      an_o    <= AN_OFF;
      seg_o   <= SEG_OFF;
      dp_o    <= 1'b1;
    end else begin
      presc <= slot_tc ? '0 : presc + 1'b1;
      if (slot_tc) begin
        slot <= slot + 2'd1;
      end
      if (upd_i) begin
        sh_hr1  <= hr1_i;
        sh_hr2  <= hr2_i;
        sh_min1 <= min1_i;
        sh_min2 <= min2_i;
      end
      if (sec_tick_i) begin
        colon_q <= ~colon_q;
      end
      an_o  <= an_nxt;
      seg_o <= seg_nxt;
      dp_o  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_wyswietlacz_mux.sv
// Bench for wyswietlacz_mux: table-driven digit vectors, hand-written colon/reset/anti-tearing
// sequences, and randomized stimulus against a cycle-count reference model.
// Two instances (leading-zero blanking on and off) share all inputs.
module tb_wyswietlacz_mux;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       upd = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] hr1 = '0;
  logic [3:0] hr2 = '0;
  logic [3:0] min1 = '0;
  logic [3:0] min2 = '0;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int n_chk = 0;
  int n_err = 0;

  wyswietlacz_mux #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut_lz1 (
    .clk_i(clk), .rst_i(rst), .hr1_i(hr1), .hr2_i(hr2), .min1_i(min1), .min2_i(min2),
    .upd_i(upd), .sec_tick_i(tick), .an_o(an_a), .seg_o(seg_a), .dp_o(dp_a)
  );

  wyswietlacz_mux #(.REFRESH_DIV(DIV), .BLANK_LZ(0)) dut_lz0 (
    .clk_i(clk), .rst_i(rst), .hr1_i(hr1), .hr2_i(hr2), .min1_i(min1), .min2_i(min2),
    .upd_i(upd), .sec_tick_i(tick), .an_o(an_b), .seg_o(seg_b), .dp_o(dp_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int s);
    case (s)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Slot is derived from the number of clocks since reset: each slot lasts DIV clocks.
  int         m_k;
  int         m_s;
  logic [3:0] m_sh [4];
  bit         m_col;
  bit         m_on = 1'b0;
  bit         m_blank;
  logic [3:0] e_an_a, e_an_b;
  logic [6:0] e_seg_a, e_seg_b;
  logic       e_dp;

  always @(posedge clk) begin
    if (rst) begin
      e_an_a = 4'hF; e_an_b = 4'hF; e_seg_a = 7'h7F; e_seg_b = 7'h7F; e_dp = 1'b1;
      m_k = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
      m_col = 1'b0;
    end else begin
      m_s     = (m_k / DIV) % 4;
      m_blank = (m_s == 3) && (m_sh[3] == 4'd0);
      e_an_b  = an_of(m_s);
      e_seg_b = dec(m_sh[m_s]);
      e_an_a  = m_blank ? 4'hF : e_an_b;
      e_seg_a = m_blank ? 7'h7F : e_seg_b;
      e_dp    = !((m_s == 2) && m_col);
      m_k++;
      if (upd) begin
        m_sh[0] = min2; m_sh[1] = min1; m_sh[2] = hr2; m_sh[3] = {2'b00, hr1};
      end
      if (tick) m_col = !m_col;
    end
    m_on = 1'b1;
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("model_an_lz1",  an_a,  e_an_a);
      check("model_seg_lz1", seg_a, e_seg_a);
      check("model_dp_lz1",  dp_a,  e_dp);
      check("model_an_lz0",  an_b,  e_an_b);
      check("model_seg_lz0", seg_b, e_seg_b);
      check("model_dp_lz0",  dp_b,  e_dp);
    end
  end

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic [1:0]      hr1;
    logic [3:0]      hr2;
    logic [3:0]      min1;
    logic [3:0]      min2;
    logic [3:0][6:0] seg;     // {slot3, slot2, slot1, slot0}, unblanked patterns
    logic            blank3;  // slot 3 blanked when leading-zero suppression is on
  } vec_t;

  vec_t vecs [5];
  vec_t v59;

  // After the j-th clock following reset release the pins show slot (j/DIV)%4.
  task automatic vcheck(input vec_t v, input int j);
    int  s;
    bit  b;
    s = (j / DIV) % 4;
    b = v.blank3 && (s == 3);
    check("vec_an_lz1",  an_a,  b ? 4'hF : an_of(s));
    check("vec_seg_lz1", seg_a, b ? 7'h7F : v.seg[s]);
    check("vec_an_lz0",  an_b,  an_of(s));
    check("vec_seg_lz0", seg_b, v.seg[s]);
    check("vec_dp",      dp_a,  1'b1);
  endtask

  task automatic start_with(input vec_t v);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; upd = 1'b1;
    hr1 = v.hr1; hr2 = v.hr2; min1 = v.min1; min2 = v.min2;
    @(negedge clk);
    upd = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd1, 4'd2, 4'd3, 4'd4,
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0};
    vecs[1] = '{2'd0, 4'd7, 4'd0, 4'd5,
                {7'b1000000, 7'b1111000, 7'b1000000, 7'b0010010}, 1'b1};
    vecs[2] = '{2'd2, 4'd3, 4'd5, 4'hB,
                {7'b0100100, 7'b0110000, 7'b0010010, 7'b0111111}, 1'b0};
    vecs[3] = '{2'd1, 4'd9, 4'd8, 4'd6,
                {7'b1111001, 7'b0010000, 7'b0000000, 7'b0000010}, 1'b0};
    vecs[4] = '{2'd2, 4'hE, 4'd0, 4'hA,
                {7'b0100100, 7'b0111111, 7'b1000000, 7'b0111111}, 1'b0};
    v59     = '{2'd2, 4'd3, 4'd5, 4'd9,
                {7'b0100100, 7'b0110000, 7'b0010010, 7'b0010000}, 1'b0};

    // Reset held three cycles.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_an",  an_a,  4'b1111);
      check("rst_seg", seg_a, 7'b1111111);
      check("rst_dp",  dp_a,  1'b1);
    end

    // Colon: tick on the first clock after release, second tick later; reset during slot 2.
    rst = 1'b0; tick = 1'b1;
    @(negedge clk);
    check("first_an",  an_a,  4'b1110);
    check("first_seg", seg_a, 7'b1000000);
    tick = 1'b0;
    for (int j = 1; j <= 41; j++) begin
      @(negedge clk);
      check("colon_dp", dp_a, (j <= 20 && j >= 8 && j <= 11) ? 1'b0 : 1'b1);
      tick = (j == 19);
    end
    check("pre_rst_slot2", an_a, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an",  an_a,  4'b1111);
    check("midrst_seg", seg_a, 7'b1111111);
    check("midrst_dp",  dp_a,  1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("resume_an",  an_a,  4'b1110);
    check("resume_seg", seg_a, 7'b1000000);
    check("resume_dp",  dp_a,  1'b1);

    // Table vectors: latch on the first clock after reset, then scan a full round.
    for (int k = 0; k < 5; k++) begin
      start_with(vecs[k]);
      for (int j = 1; j <= 19; j++) begin
        @(negedge clk);
        vcheck(vecs[k], j);
      end
    end

    // Anti-tearing: live inputs change without a strobe; strobe lands on a slot terminal count.
    start_with(vecs[0]);
    hr1 = v59.hr1; hr2 = v59.hr2; min1 = v59.min1; min2 = v59.min2;
    for (int j = 1; j <= 36; j++) begin
      @(negedge clk);
      vcheck((j < 32) ? vecs[0] : v59, j);
      upd = (j == 30);
    end

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hr1  = 2'($urandom_range(0, 3));
      hr2  = 4'($urandom_range(0, 15));
      min1 = 4'($urandom_range(0, 15));
      min2 = 4'($urandom_range(0, 15));
      upd  = ($urandom_range(0, 7) == 0);
      tick = ($urandom_range(0, 15) == 0);
      rst  = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0; upd = 1'b0; tick = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
